// File: rtl/fab_clk_timebase.sv
// fab_clk_timebase
//   Reset sequencer and fabric timebase running on FAB_CLK.
//   - Holds SYS_RESET high for RST_HOLD_CYCLES cycles after RESET releases.
//   - Once running, produces a 1 us tick, the N64 bit-cell quarter phase and
//     strobe, a 1 ms tick and a free-running 16-bit microsecond timestamp.
//   - SYNC_CLR realigns the dividers so the next 1 us tick lands US_DIV
//     cycles after the request cycle; the timestamp keeps counting.
//   Optional build macro FAB_CLK_TIMEBASE_LOCK_GATE_EN: when defined, the
//   sequencer also requires FAB_LOCK=1 to leave reset, and any loss of lock
//   sends it back to reset. When undefined, FAB_LOCK is ignored.
module fab_clk_timebase #(
    parameter int unsigned CLK_FREQ_HZ     = 100000000,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned MS_DIV          = 1000
) (
    input  logic        FAB_CLK,
    input  logic        RESET,
    input  logic        FAB_LOCK,
    input  logic        SYNC_CLR,
    output logic        SYS_RESET,
    output logic        TICK_1US,
    output logic [1:0]  BIT_PHASE,
    output logic        BIT_STROBE,
    output logic        TICK_1MS,
    output logic [15:0] US_COUNT
);

    localparam int unsigned US_DIV = CLK_FREQ_HZ / 1000000;
    localparam int unsigned DIV_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(US_DIV - 1);
    localparam logic [MS_W-1:0]  MS_LAST   = MS_W'(MS_DIV - 1);
    localparam logic [15:0]      HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);

    // Parameter sanity: the tick pipeline needs at least two cycles per us.
    if (((CLK_FREQ_HZ % 1000000) != 0) || (CLK_FREQ_HZ < 2000000)) begin : g_bad_clk
        $error("fab_clk_timebase: CLK_FREQ_HZ must be a multiple of 1 MHz and >= 2 MHz");
    end
    if ((RST_HOLD_CYCLES < 1) || (RST_HOLD_CYCLES > 65535)) begin : g_bad_hold
        $error("fab_clk_timebase: RST_HOLD_CYCLES must be in 1..65535");
    end
    if (MS_DIV < 1) begin : g_bad_ms
        $error("fab_clk_timebase: MS_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [15:0]       hold_cnt_r;
    logic [15:0]       hold_cnt_s;
    logic              lock_ok_s;

    logic [DIV_W-1:0]  div_cnt_r;
    logic [DIV_W-1:0]  div_cnt_s;
    logic [MS_W-1:0]   ms_cnt_r;
    logic [MS_W-1:0]   ms_cnt_s;
    logic [1:0]        bit_phase_r;
    logic [1:0]        bit_phase_s;
    logic [15:0]       us_count_r;
    logic [15:0]       us_count_s;
    logic              sys_reset_r;
    logic              sys_reset_s;
    logic              tick_1us_r;
    logic              tick_1us_s;
    logic              bit_strobe_r;
    logic              bit_strobe_s;
    logic              tick_1ms_r;
    logic              tick_1ms_s;
    logic              run_s;
    logic              tick_due_s;

`ifdef FAB_CLK_TIMEBASE_LOCK_GATE_EN
    assign lock_ok_s = FAB_LOCK;
`else
    // In the CCC bypass build FAB_LOCK is tied low and deliberately ignored.
    logic unused_fab_lock_s;
    assign unused_fab_lock_s = FAB_LOCK;
    assign lock_ok_s         = 1'b1;
`endif

    // Reset sequencer next state: RESET (or lost lock) always wins, then hold count-down.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = 16'd0;
        if (RESET || !lock_ok_s) begin
            state_s = S_RESET;
        end else begin
            case (state_r)
                S_RESET: begin
                    state_s = S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_s = S_RUN;
                    end else begin
                        state_s    = S_HOLD;
                        hold_cnt_s = hold_cnt_r + 16'd1;
                    end
                end
                S_RUN: begin
                    state_s = S_RUN;
                end
                default: begin
                    state_s = S_RESET;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_r    <= S_RESET;
            hold_cnt_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // Timebase next values: dividers only advance while staying in S_RUN; SYNC_CLR beats the tick.
    always_comb begin
        run_s        = (state_r == S_RUN) && (state_s == S_RUN);
        tick_due_s   = (div_cnt_r == DIV_LAST);
        sys_reset_s  = (state_s != S_RUN);
        div_cnt_s    = DIV_W'(0);
        ms_cnt_s     = MS_W'(0);
        bit_phase_s  = 2'd0;
        us_count_s   = 16'd0;
        tick_1us_s   = 1'b0;
        bit_strobe_s = 1'b0;
        tick_1ms_s   = 1'b0;
        if (run_s) begin
            // The timestamp follows the tick already on the output, even across a realign.
            if (tick_1us_r) begin
                us_count_s = us_count_r + 16'd1;
            end else begin
                us_count_s = us_count_r;
            end
            if (SYNC_CLR) begin
                div_cnt_s    = DIV_W'(0);
                ms_cnt_s     = MS_W'(0);
                bit_phase_s  = 2'd0;
                tick_1us_s   = 1'b0;
                bit_strobe_s = 1'b0;
                tick_1ms_s   = 1'b0;
            end else begin
                if (tick_due_s) begin
                    div_cnt_s = DIV_W'(0);
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
                tick_1us_s   = tick_due_s;
                bit_strobe_s = tick_due_s && (bit_phase_r == 2'd3);
                tick_1ms_s   = tick_due_s && (ms_cnt_r == MS_LAST);
                if (tick_1us_r) begin
                    bit_phase_s = bit_phase_r + 2'd1;
                    if (ms_cnt_r == MS_LAST) begin
                        ms_cnt_s = MS_W'(0);
                    end else begin
                        ms_cnt_s = ms_cnt_r + MS_W'(1);
                    end
                end else begin
                    bit_phase_s = bit_phase_r;
                    ms_cnt_s    = ms_cnt_r;
                end
            end
        end else begin
            div_cnt_s    = DIV_W'(0);
            ms_cnt_s     = MS_W'(0);
            bit_phase_s  = 2'd0;
            us_count_s   = 16'd0;
            tick_1us_s   = 1'b0;
            bit_strobe_s = 1'b0;
            tick_1ms_s   = 1'b0;
        end
    end

    // Timebase counters and registered outputs.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            sys_reset_r  <= 1'b1;
            div_cnt_r    <= DIV_W'(0);
            ms_cnt_r     <= MS_W'(0);
            bit_phase_r  <= 2'd0;
            us_count_r   <= 16'd0;
            tick_1us_r   <= 1'b0;
            bit_strobe_r <= 1'b0;
            tick_1ms_r   <= 1'b0;
        end else begin
            sys_reset_r  <= sys_reset_s;
            div_cnt_r    <= div_cnt_s;
            ms_cnt_r     <= ms_cnt_s;
            bit_phase_r  <= bit_phase_s;
            us_count_r   <= us_count_s;
            tick_1us_r   <= tick_1us_s;
            bit_strobe_r <= bit_strobe_s;
            tick_1ms_r   <= tick_1ms_s;
        end
    end

    assign SYS_RESET  = sys_reset_r;
    assign TICK_1US   = tick_1us_r;
    assign BIT_PHASE  = bit_phase_r;
    assign BIT_STROBE = bit_strobe_r;
    assign TICK_1MS   = tick_1ms_r;
    assign US_COUNT   = us_count_r;

endmodule
